// File: rtl/galaxian_pkg.sv
// rtl/galaxian_pkg.sv - shared motion codes, formation state enum and sprite constants for the alien wave
package galaxian_pkg;

  localparam logic [1:0] MC_RIGHT  = 2'b00;
  localparam logic [1:0] MC_LEFT   = 2'b01;
  localparam logic [1:0] MC_DOWN_R = 2'b10;
  localparam logic [1:0] MC_DOWN_L = 2'b11;

  localparam int ALIEN_SIZE = 25;

  typedef enum logic [2:0] {
    MOVE_R  = 3'd0,
    DESC_L  = 3'd1,
    MOVE_L  = 3'd2,
    DESC_R  = 3'd3,
    CLEARED = 3'd4
  } form_state_t;

  function automatic logic [1:0] state_motion_code(input form_state_t s);
    case (s)
      DESC_L:  return MC_DOWN_L;
      MOVE_L:  return MC_LEFT;
      DESC_R:  return MC_DOWN_R;
      default: return MC_RIGHT;
    endcase
  endfunction

  function automatic logic signed [1:0] motion_dx(input logic [1:0] mc);
    case (mc)
      MC_RIGHT: return 2'sb01;
      MC_LEFT:  return 2'sb11;
      default:  return 2'sb00;
    endcase
  endfunction

  // Both descend codes have bit 1 set; the horizontal hint in bit 0 does not move x.
  function automatic logic motion_dy(input logic [1:0] mc);
    return mc[1];
  endfunction

endpackage

// File: rtl/col_extent_enc.sv
// rtl/col_extent_enc.sv - lowest/highest live column encoders over the per-column alive mask
module col_extent_enc #(
  parameter int NUM_COLS = 10,
  parameter int IDX_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic [NUM_COLS-1:0] i_col_alive,
  output logic [IDX_W-1:0]    o_lc,
  output logic [IDX_W-1:0]    o_rc,
  output logic                o_any_alive
);

  always_comb begin
    o_lc = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (i_col_alive[i]) o_lc = IDX_W'(i);
    end
  end

  always_comb begin
    o_rc = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (i_col_alive[i]) o_rc = IDX_W'(i);
    end
  end

  assign o_any_alive = |i_col_alive;

endmodule

// File: rtl/alien_formation_ctrl.sv
// rtl/alien_formation_ctrl.sv - formation sweep sequencer driving the shared motion_code bus
module alien_formation_ctrl
  import galaxian_pkg::*;
#(
  parameter int NUM_COLS    = 10,
  parameter int COL_PITCH   = 32,
  parameter int ALIEN_SIZE  = galaxian_pkg::ALIEN_SIZE,
  parameter int FORM_X0     = 100,
  parameter int FORM_Y0     = 40,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639,
  parameter int EDGE_MARGIN = 2,
  parameter int DROP_FRAMES = 8,
  parameter int Y_FLOOR     = 300
) (
  input  logic                frame_clk,
  input  logic                Reset_n,
  input  logic [NUM_COLS-1:0] col_alive,
  output logic [1:0]          motion_code,
  output logic signed [10:0]  form_x,
  output logic [9:0]          form_y,
  output logic                at_floor,
  output logic                wave_cleared
);

  localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int DCW   = (DROP_FRAMES > 1) ? $clog2(DROP_FRAMES) : 1;

  localparam logic [DCW-1:0]     C_DROP_LAST = DCW'(DROP_FRAMES - 1);
  localparam logic signed [11:0] C_LEFT_LIM  = 12'(X_MIN + EDGE_MARGIN);
  localparam logic signed [11:0] C_RIGHT_LIM = 12'(X_MAX - EDGE_MARGIN);
  localparam logic signed [11:0] C_SPAN      = 12'(ALIEN_SIZE - 1);
  localparam logic [9:0]         C_Y_FLOOR   = 10'(Y_FLOOR);

  logic [IDX_W-1:0]   w_lc;
  logic [IDX_W-1:0]   w_rc;
  logic               w_any_alive;
  logic signed [11:0] w_x12;
  logic signed [11:0] w_lc_off;
  logic signed [11:0] w_rc_off;
  logic signed [11:0] w_left_ext;
  logic signed [11:0] w_right_ext;
  logic               w_hit_left;
  logic               w_hit_right;

  form_state_t        r_state;
  form_state_t        w_next_state;
  logic [DCW-1:0]     r_drop_cnt;
  logic [DCW-1:0]     w_drop_next;
  logic [1:0]         r_motion_code;
  logic               r_wave_cleared;
  logic signed [1:0]  r_dx_q;
  logic               r_dy_q;
  logic signed [10:0] r_form_x;
  logic [9:0]         r_form_y;

  col_extent_enc #(
    .NUM_COLS (NUM_COLS),
    .IDX_W    (IDX_W)
  ) u_extent (
    .i_col_alive (col_alive),
    .o_lc        (w_lc),
    .o_rc        (w_rc),
    .o_any_alive (w_any_alive)
  );

  // Extents are widened to 12 bits so a formation parked left of x=0 compares correctly.
  assign w_x12       = {r_form_x[10], r_form_x};
  assign w_lc_off    = 12'(32'(w_lc) * COL_PITCH);
  assign w_rc_off    = 12'(32'(w_rc) * COL_PITCH);
  assign w_left_ext  = w_x12 + w_lc_off;
  assign w_right_ext = w_x12 + w_rc_off + C_SPAN;
  assign w_hit_right = (w_right_ext >= C_RIGHT_LIM);
  assign w_hit_left  = (w_left_ext <= C_LEFT_LIM);

  assign at_floor = (r_form_y >= C_Y_FLOOR);

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= MOVE_R;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_drop_cnt <= w_drop_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_drop_next  = r_drop_cnt;
    case (r_state)
      MOVE_R: begin
        if (w_hit_right) begin
          w_next_state = at_floor ? MOVE_L : DESC_L;
          w_drop_next  = '0;
        end
      end
      DESC_L: begin
        w_drop_next = r_drop_cnt + DCW'(1);
        if (r_drop_cnt == C_DROP_LAST) w_next_state = MOVE_L;
      end
      MOVE_L: begin
        if (w_hit_left) begin
          w_next_state = at_floor ? MOVE_R : DESC_R;
          w_drop_next  = '0;
        end
      end
      DESC_R: begin
        w_drop_next = r_drop_cnt + DCW'(1);
        if (r_drop_cnt == C_DROP_LAST) w_next_state = MOVE_R;
      end
      CLEARED: w_next_state = CLEARED;
      default: w_next_state = MOVE_R;
    endcase
    if (!w_any_alive) w_next_state = CLEARED;
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_motion_code  <= MC_RIGHT;
      r_wave_cleared <= 1'b0;
    end else begin
      r_motion_code  <= state_motion_code(w_next_state);
      r_wave_cleared <= r_wave_cleared | ~w_any_alive;
    end
  end

  // Two-stage mirror: the aliens latch motion_code one frame before applying it.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_dx_q   <= '0;
      r_dy_q   <= 1'b0;
      r_form_x <= 11'(FORM_X0);
      r_form_y <= 10'(FORM_Y0);
    end else begin
      r_dx_q   <= motion_dx(r_motion_code);
      r_dy_q   <= motion_dy(r_motion_code);
      r_form_x <= r_form_x + 11'(r_dx_q);
      r_form_y <= r_form_y + 10'(r_dy_q);
    end
  end

  assign motion_code  = r_motion_code;
  assign form_x       = r_form_x;
  assign form_y       = r_form_y;
  assign wave_cleared = r_wave_cleared;

endmodule

// File: tb/tb_alien_formation_ctrl.sv
// tb/tb_alien_formation_ctrl.sv - scoreboard bench for alien_formation_ctrl
module tb_alien_formation_ctrl;

  typedef struct {
    logic [1:0] mc;
    int         fx;
    int         fy;
    logic       wc;
  } exp_t;

  logic               frame_clk = 1'b0;
  logic               Reset_n   = 1'b0;
  logic               rst_n_b   = 1'b0;
  logic [9:0]         col_alive = 10'h3FF;
  logic [1:0]         mc_a, mc_b;
  logic signed [10:0] fx_a, fx_b;
  logic [9:0]         fy_a, fy_b;
  logic               af_a, af_b, wc_a, wc_b;

  exp_t       q_a[$];
  exp_t       q_b[$];
  exp_t       e_a, e_b;
  logic [2:0] prev_a = 3'b000;
  logic [2:0] prev_b = 3'b000;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 frame_clk = ~frame_clk;

  alien_formation_ctrl u_dut_a (
    .frame_clk    (frame_clk),
    .Reset_n      (Reset_n),
    .col_alive    (col_alive),
    .motion_code  (mc_a),
    .form_x       (fx_a),
    .form_y       (fy_a),
    .at_floor     (af_a),
    .wave_cleared (wc_a)
  );

  alien_formation_ctrl #(.FORM_Y0(300)) u_dut_b (
    .frame_clk    (frame_clk),
    .Reset_n      (rst_n_b),
    .col_alive    (col_alive),
    .motion_code  (mc_b),
    .form_x       (fx_b),
    .form_y       (fy_b),
    .at_floor     (af_b),
    .wave_cleared (wc_b)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input bit to_b, input logic [1:0] mc, input int fx, input int fy, input logic wc);
    exp_t e = '{mc, fx, fy, wc};
    if (to_b) q_b.push_back(e);
    else      q_a.push_back(e);
  endtask

  always @(negedge frame_clk) begin
    if (!Reset_n) prev_a = 3'b000;
    else if ({mc_a, wc_a} != prev_a) begin
      prev_a = {mc_a, wc_a};
      if (q_a.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL mon_a_unexpected: mc=%0d wc=%0d fx=%0d with no event expected", mc_a, wc_a, fx_a);
      end else begin
        e_a = q_a.pop_front();
        check("mon_a_motion_code", int'(mc_a), int'(e_a.mc));
        check("mon_a_form_x", int'($signed(fx_a)), e_a.fx);
        check("mon_a_form_y", int'(fy_a), e_a.fy);
        check("mon_a_wave_cleared", int'(wc_a), int'(e_a.wc));
      end
    end
  end

  always @(negedge frame_clk) begin
    if (!rst_n_b) prev_b = 3'b000;
    else if ({mc_b, wc_b} != prev_b) begin
      prev_b = {mc_b, wc_b};
      if (q_b.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL mon_b_unexpected: mc=%0d wc=%0d fx=%0d with no event expected", mc_b, wc_b, fx_b);
      end else begin
        e_b = q_b.pop_front();
        check("mon_b_motion_code", int'(mc_b), int'(e_b.mc));
        check("mon_b_form_x", int'($signed(fx_b)), e_b.fx);
        check("mon_b_form_y", int'(fy_b), e_b.fy);
        check("mon_b_wave_cleared", int'(wc_b), int'(e_b.wc));
      end
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge frame_clk);
    @(negedge frame_clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while ((q_a.size() + q_b.size()) != 0 && k < budget) begin
      @(negedge frame_clk);
      #1;
      k++;
    end
    check({name, "_events_seen"}, q_a.size() + q_b.size(), 0);
    q_a.delete();
    q_b.delete();
  endtask

  task automatic do_reset(input logic [9:0] alive, input bit run_b);
    Reset_n   = 1'b0;
    rst_n_b   = 1'b0;
    col_alive = alive;
    @(negedge frame_clk);
    @(negedge frame_clk);
    #1;
    check("rst_motion_code", int'(mc_a), 0);
    check("rst_form_x", int'($signed(fx_a)), 100);
    check("rst_form_y", int'(fy_a), 40);
    check("rst_at_floor", int'(af_a), 0);
    check("rst_wave_cleared", int'(wc_a), 0);
    if (run_b) begin
      check("rst_b_at_floor", int'(af_b), 1);
      check("rst_b_form_y", int'(fy_b), 300);
      check("rst_b_motion_code", int'(mc_b), 0);
    end
    #1;
    Reset_n = 1'b1;
    rst_n_b = run_b;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Full formation; second instance starts on the floor and must never descend.
    do_reset(10'h3FF, 1'b1);
    wait_edges(1);
    check("t1_edge1_form_x", int'($signed(fx_a)), 100);
    check("t1_edge1_motion_code", int'(mc_a), 0);
    wait_edges(1);
    check("t1_edge2_form_x", int'($signed(fx_a)), 101);
    push(1'b0, 2'b11, 326, 40, 1'b0);
    push(1'b0, 2'b01, 327, 47, 1'b0);
    push(1'b0, 2'b10, 1, 48, 1'b0);
    push(1'b0, 2'b00, 0, 55, 1'b0);
    push(1'b1, 2'b01, 326, 300, 1'b0);
    push(1'b1, 2'b00, 1, 300, 1'b0);
    wait_drain("t1", 700);
    check("t1_b_form_y_const", int'(fy_b), 300);
    rst_n_b = 1'b0;

    // Left five columns only: right edge reached further out.
    do_reset(10'h01F, 1'b0);
    push(1'b0, 2'b11, 486, 40, 1'b0);
    push(1'b0, 2'b01, 487, 47, 1'b0);
    wait_drain("t2", 500);

    // Right five columns: left turn happens with form_x negative.
    do_reset(10'h3E0, 1'b0);
    push(1'b0, 2'b11, 326, 40, 1'b0);
    push(1'b0, 2'b01, 327, 47, 1'b0);
    push(1'b0, 2'b10, -159, 48, 1'b0);
    push(1'b0, 2'b00, -160, 55, 1'b0);
    wait_drain("t3", 900);

    // Wave cleared mid-sweep is terminal.
    do_reset(10'h3FF, 1'b0);
    wait_edges(50);
    check("t5_pre_clear_form_x", int'($signed(fx_a)), 149);
    col_alive = 10'h000;
    push(1'b0, 2'b00, 150, 40, 1'b1);
    wait_drain("t5", 5);
    col_alive = 10'h3FF;
    wait_edges(10);
    check("t5_sticky_wave_cleared", int'(wc_a), 1);
    check("t5_cleared_motion_code", int'(mc_a), 0);

    // Asynchronous reset in the middle of a descent, then a fresh run.
    do_reset(10'h3FF, 1'b0);
    push(1'b0, 2'b11, 326, 40, 1'b0);
    wait_edges(231);
    check("t6_desc_entered", q_a.size(), 0);
    check("t6_mid_desc_code", int'(mc_a), 3);
    check("t6_mid_desc_form_y", int'(fy_a), 43);
    #1;
    Reset_n = 1'b0;
    #1;
    check("t6_async_motion_code", int'(mc_a), 0);
    check("t6_async_form_x", int'($signed(fx_a)), 100);
    check("t6_async_form_y", int'(fy_a), 40);
    check("t6_async_wave_cleared", int'(wc_a), 0);
    @(negedge frame_clk);
    #2;
    Reset_n = 1'b1;
    push(1'b0, 2'b11, 326, 40, 1'b0);
    push(1'b0, 2'b01, 327, 47, 1'b0);
    wait_drain("t6", 400);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
